// File: rtl/cok_cevrim_denetleyici_if.sv
// Start/done/abort link between the multi-cycle controller (master) and the shared
// iterative MUL/DIV unit (slave).
interface cok_cevrim_denetleyici_if #(
    parameter int VERI_BIT  = 32,
    parameter int ISLEM_BIT = 4
);
    logic                 birim_basla_o;
    logic [ISLEM_BIT-1:0] birim_islem_o;
    logic [VERI_BIT-1:0]  birim_islec1_o;
    logic [VERI_BIT-1:0]  birim_islec2_o;
    logic                 birim_iptal_o;
    logic                 birim_bitti_i;
    logic [VERI_BIT-1:0]  birim_sonuc_i;

    modport master (
        output birim_basla_o,
        output birim_islem_o,
        output birim_islec1_o,
        output birim_islec2_o,
        output birim_iptal_o,
        input  birim_bitti_i,
        input  birim_sonuc_i
    );

    modport slave (
        input  birim_basla_o,
        input  birim_islem_o,
        input  birim_islec1_o,
        input  birim_islec2_o,
        input  birim_iptal_o,
        output birim_bitti_i,
        output birim_sonuc_i
    );
endinterface

// File: rtl/cok_cevrim_denetleyici.sv
// Execute-stage sequencer for the shared multi-cycle MUL/DIV unit: latches the uop,
// launches the unit, stalls the pipe until done/timeout/flush and presents the result.
module cok_cevrim_denetleyici #(
    parameter int VERI_BIT    = 32,
    parameter int ISLEM_BIT   = 4,
    parameter int ETIKET_BIT  = 4,
    parameter int ZAMAN_ASIMI = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  istek_gecerli_i,
    input  logic [ISLEM_BIT-1:0]  istek_islem_i,
    input  logic [VERI_BIT-1:0]   istek_islec1_i,
    input  logic [VERI_BIT-1:0]   istek_islec2_i,
    input  logic [ETIKET_BIT-1:0] istek_etiket_i,
    input  logic                  bosalt_i,
    input  logic                  cek_duraklat_i,
    cok_cevrim_denetleyici_if.master birim,
    output logic                  duraklat_o,
    output logic                  sonuc_gecerli_o,
    output logic [VERI_BIT-1:0]   sonuc_o,
    output logic [ETIKET_BIT-1:0] sonuc_etiket_o,
    output logic                  zaman_asimi_o
);
    localparam int SAYAC_BIT = $clog2(ZAMAN_ASIMI) + 1;
    localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(ZAMAN_ASIMI - 1);
    localparam logic [SAYAC_BIT-1:0] SAYAC_BIR = {{(SAYAC_BIT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        BASLAT = 2'd1,
        BEKLE  = 2'd2,
        SONUC  = 2'd3
    } durum_t;

    durum_t                 durum_r;
    logic [SAYAC_BIT-1:0]   sayac_r;
    logic [ISLEM_BIT-1:0]   islem_r;
    logic [VERI_BIT-1:0]    islec1_r;
    logic [VERI_BIT-1:0]    islec2_r;
    logic [ETIKET_BIT-1:0]  etiket_r;
    logic [VERI_BIT-1:0]    sonuc_r;
    logic                   asim_r;

    logic sure_doldu_s;
    logic basla_s;
    logic iptal_s;
    logic duraklat_s;
    logic gecerli_s;

    assign sure_doldu_s = (sayac_r == SAYAC_SON);

    // Strobes come from the registered state; flush and done only gate them within the cycle.
    always_comb begin
        basla_s    = 1'b0;
        iptal_s    = 1'b0;
        duraklat_s = 1'b0;
        gecerli_s  = 1'b0;
        case (durum_r)
            BOSTA: begin
                duraklat_s = istek_gecerli_i & ~bosalt_i;
            end
            BASLAT: begin
                basla_s    = ~bosalt_i;
                iptal_s    = bosalt_i;
                duraklat_s = ~bosalt_i;
            end
            BEKLE: begin
                // A result arriving in the same cycle means the unit is already idle.
                iptal_s    = ~birim.birim_bitti_i & (bosalt_i | sure_doldu_s);
                duraklat_s = ~bosalt_i;
            end
            SONUC: begin
                gecerli_s  = ~bosalt_i;
            end
            default: begin
                basla_s    = 1'b0;
                iptal_s    = 1'b0;
                duraklat_s = 1'b0;
                gecerli_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state, timeout counter and latched uop/result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_r  <= BOSTA;
            sayac_r  <= {SAYAC_BIT{1'b0}};
            islem_r  <= {ISLEM_BIT{1'b0}};
            islec1_r <= {VERI_BIT{1'b0}};
            islec2_r <= {VERI_BIT{1'b0}};
            etiket_r <= {ETIKET_BIT{1'b0}};
            sonuc_r  <= {VERI_BIT{1'b0}};
            asim_r   <= 1'b0;
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (istek_gecerli_i && !bosalt_i) begin
                        islem_r  <= istek_islem_i;
                        islec1_r <= istek_islec1_i;
                        islec2_r <= istek_islec2_i;
                        etiket_r <= istek_etiket_i;
                        durum_r  <= BASLAT;
                    end
                end
                BASLAT: begin
                    sayac_r <= {SAYAC_BIT{1'b0}};
                    durum_r <= bosalt_i ? BOSTA : BEKLE;
                end
                BEKLE: begin
                    if (!sure_doldu_s) begin
                        sayac_r <= sayac_r + SAYAC_BIR;
                    end
                    if (bosalt_i) begin
                        durum_r <= BOSTA;
                    end else if (birim.birim_bitti_i) begin
                        sonuc_r <= birim.birim_sonuc_i;
                        asim_r  <= 1'b0;
                        durum_r <= SONUC;
                    end else if (sure_doldu_s) begin
                        sonuc_r <= {VERI_BIT{1'b1}};
                        asim_r  <= 1'b1;
                        durum_r <= SONUC;
                    end
                end
                SONUC: begin
                    // Leaving here releases the stall, so the held uop moves on and is not relaunched.
                    if (bosalt_i || !cek_duraklat_i) begin
                        durum_r <= BOSTA;
                    end
                end
                default: begin
                    durum_r <= BOSTA;
                end
            endcase
        end
    end

    assign birim.birim_basla_o  = basla_s;
    assign birim.birim_iptal_o  = iptal_s;
    assign birim.birim_islem_o  = islem_r;
    assign birim.birim_islec1_o = islec1_r;
    assign birim.birim_islec2_o = islec2_r;

    // Reset forces the stall low even while a uop is still presented.
    assign duraklat_o      = duraklat_s & ~rst_i;
    assign sonuc_gecerli_o = gecerli_s;
    assign sonuc_o         = sonuc_r;
    assign sonuc_etiket_o  = etiket_r;
    assign zaman_asimi_o   = asim_r & gecerli_s;
endmodule

// File: tb/tb_cok_cevrim_denetleyici.sv
// Bench for cok_cevrim_denetleyici: directed scenarios plus randomized uops checked
// against a per-transaction timeline computed from the protocol rules.
module tb_cok_cevrim_denetleyici;
    localparam int VB = 32;
    localparam int IB = 4;
    localparam int EB = 4;
    localparam int ZA = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          istek_gecerli_i = 1'b0;
    logic [IB-1:0] istek_islem_i = '0;
    logic [VB-1:0] istek_islec1_i = '0;
    logic [VB-1:0] istek_islec2_i = '0;
    logic [EB-1:0] istek_etiket_i = '0;
    logic          bosalt_i = 1'b0;
    logic          cek_duraklat_i = 1'b0;
    logic          duraklat_o;
    logic          sonuc_gecerli_o;
    logic [VB-1:0] sonuc_o;
    logic [EB-1:0] sonuc_etiket_o;
    logic          zaman_asimi_o;

    int total = 0;
    int bad   = 0;

    cok_cevrim_denetleyici_if #(.VERI_BIT(VB), .ISLEM_BIT(IB)) birim_if ();

    cok_cevrim_denetleyici #(
        .VERI_BIT(VB), .ISLEM_BIT(IB), .ETIKET_BIT(EB), .ZAMAN_ASIMI(ZA)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .istek_gecerli_i (istek_gecerli_i),
        .istek_islem_i   (istek_islem_i),
        .istek_islec1_i  (istek_islec1_i),
        .istek_islec2_i  (istek_islec2_i),
        .istek_etiket_i  (istek_etiket_i),
        .bosalt_i        (bosalt_i),
        .cek_duraklat_i  (cek_duraklat_i),
        .birim           (birim_if.master),
        .duraklat_o      (duraklat_o),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .sonuc_o         (sonuc_o),
        .sonuc_etiket_o  (sonuc_etiket_o),
        .zaman_asimi_o   (zaman_asimi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // What the unit itself would compute: opcode 1 divides, anything else multiplies.
    function automatic logic [31:0] birim_model(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        if (op == 4'd1) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        else            return a * b;
    endfunction

    task automatic sifir_kontrol(input string ad);
        chk1 ({ad, "/basla"},    birim_if.birim_basla_o, 1'b0);
        chk1 ({ad, "/iptal"},    birim_if.birim_iptal_o, 1'b0);
        chk1 ({ad, "/duraklat"}, duraklat_o,             1'b0);
        chk1 ({ad, "/gecerli"},  sonuc_gecerli_o,        1'b0);
        chk1 ({ad, "/asim"},     zaman_asimi_o,          1'b0);
        chk32({ad, "/sonuc"},    sonuc_o,                32'd0);
        chk32({ad, "/etiket"},   32'(sonuc_etiket_o),    32'd0);
        chk32({ad, "/islem"},    32'(birim_if.birim_islem_o), 32'd0);
        chk32({ad, "/islec1"},   birim_if.birim_islec1_o, 32'd0);
        chk32({ad, "/islec2"},   birim_if.birim_islec2_o, 32'd0);
    endtask

    // One uop from request (t=0) to release. d: unit done d cycles after start (0 = never);
    // tut: cycles cek_duraklat_i is held in SONUC; tf: flush cycle (-1 = none).
    task automatic islem_calistir(input string ad, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] etk,
                                  input int d, input int tut, input int tf);
        bit          bitti_var = (d >= 1) && (d <= ZA);
        int          te        = bitti_var ? d + 1 : ZA + 1;
        logic [31:0] beklenen  = bitti_var ? birim_model(op, a, b) : 32'hFFFF_FFFF;
        int          son       = (tf >= 0) ? tf + 2 : te + tut + 2;
        for (int t = 0; t <= son; t++) begin
            bit canli     = (tf < 0) || (t < tf);
            bit istek     = (tf >= 0) ? (t <= tf) : (t <= te + 1 + tut);
            bit bitti_t   = (d >= 1) && (t == d + 1);
            bit bekle_t   = (t >= 2) && (t <= te) && ((tf < 0) || (t <= tf));
            bit sonuc_faz = (t > te) && (t <= te + 1 + tut);
            bit e_basla   = canli && (t == 1);
            bit e_iptal   = canli ? ((t == te) && !bitti_var)
                                  : ((t == tf) && ((tf == 1) || (bekle_t && !bitti_t)));
            bit e_durak   = canli && istek && (t <= te);
            bit e_gecerli = canli && sonuc_faz;
            string tg;

            istek_gecerli_i = istek;
            istek_islem_i   = istek ? op  : 4'($urandom);
            istek_islec1_i  = istek ? a   : $urandom;
            istek_islec2_i  = istek ? b   : $urandom;
            istek_etiket_i  = istek ? etk : 4'($urandom);
            bosalt_i        = (t == tf);
            cek_duraklat_i  = sonuc_faz ? (t <= te + tut) : 1'($urandom_range(0, 1));
            if (bekle_t) begin
                birim_if.birim_bitti_i = bitti_t;
                birim_if.birim_sonuc_i = bitti_t ? birim_model(op, a, b) : $urandom;
            end else begin
                // Outside BEKLE the done strobe must be ignored, so throw garbage at it.
                birim_if.birim_bitti_i = bitti_t | 1'($urandom_range(0, 1));
                birim_if.birim_sonuc_i = $urandom;
            end

            @(negedge clk_i);
            tg = $sformatf("%s@%0d", ad, t);
            chk1({tg, "/basla"},    birim_if.birim_basla_o, e_basla);
            chk1({tg, "/iptal"},    birim_if.birim_iptal_o, e_iptal);
            chk1({tg, "/duraklat"}, duraklat_o,             e_durak);
            chk1({tg, "/gecerli"},  sonuc_gecerli_o,        e_gecerli);
            if (e_gecerli) begin
                chk32({tg, "/sonuc"},  sonuc_o,              beklenen);
                chk32({tg, "/etiket"}, 32'(sonuc_etiket_o),  32'(etk));
                chk1 ({tg, "/asim"},   zaman_asimi_o,        !bitti_var);
            end else begin
                chk1 ({tg, "/asim"},   zaman_asimi_o,        1'b0);
            end
            if (e_basla) begin
                chk32({tg, "/islem"},  32'(birim_if.birim_islem_o), 32'(op));
                chk32({tg, "/islec1"}, birim_if.birim_islec1_o,     a);
                chk32({tg, "/islec2"}, birim_if.birim_islec2_o,     b);
            end
            @(posedge clk_i);
            #1;
        end
        istek_gecerli_i        = 1'b0;
        bosalt_i               = 1'b0;
        birim_if.birim_bitti_i = 1'b0;
    endtask

    initial begin
        birim_if.birim_bitti_i = 1'b0;
        birim_if.birim_sonuc_i = 32'd0;

        @(negedge clk_i);
        sifir_kontrol("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        islem_calistir("T1_mul",       4'd0, 32'd7,  32'd6, 4'd3, 4,      0, -1);
        islem_calistir("T2_fast",      4'd0, 32'd11, 32'd3, 4'd5, 1,      0, -1);
        islem_calistir("T3_timeout",   4'd1, 32'd99, 32'd9, 4'd7, 0,      1, -1);
        islem_calistir("done_at_limit",4'd1, 32'd99, 32'd9, 4'd8, ZA,     0, -1);
        islem_calistir("done_late",    4'd0, 32'd4,  32'd4, 4'd9, ZA + 1, 0, -1);
        islem_calistir("T4_flush",     4'd0, 32'd3,  32'd5, 4'd1, 0,      0, 3);
        islem_calistir("T4_flush_done",4'd0, 32'd3,  32'd5, 4'd2, 2,      0, 3);
        islem_calistir("T5_hold",      4'd1, 32'd1000, 32'd7, 4'd4, 3,    3, -1);
        islem_calistir("flush_baslat", 4'd0, 32'd8,  32'd8, 4'd6, 2,      0, 1);
        islem_calistir("flush_sonuc",  4'd0, 32'd8,  32'd9, 4'd6, 2,      2, 4);
        islem_calistir("flush_bosta",  4'd0, 32'd8,  32'd9, 4'd6, 2,      0, 0);

        // T6: asynchronous reset in the middle of BEKLE with the uop still presented.
        istek_gecerli_i = 1'b1;
        istek_islem_i   = 4'd0;
        istek_islec1_i  = 32'd5;
        istek_islec2_i  = 32'd9;
        istek_etiket_i  = 4'd2;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
        end
        #2;
        rst_i = 1'b1;
        #1;
        sifir_kontrol("T6_async");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        istek_gecerli_i = 1'b0;
        islem_calistir("T6_after", 4'd0, 32'd7, 32'd6, 4'd3, 4, 0, -1);

        for (int i = 0; i < 30; i++) begin
            logic [3:0]  op  = 4'($urandom_range(0, 1));
            logic [31:0] a   = $urandom;
            logic [31:0] b   = (op == 4'd1) ? 32'($urandom_range(1, 1000)) : $urandom;
            logic [3:0]  etk = 4'($urandom);
            int d   = $urandom_range(0, ZA + 2);
            int tut = $urandom_range(0, 3);
            int te  = ((d >= 1) && (d <= ZA)) ? d + 1 : ZA + 1;
            int tf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, te + 1 + tut)) : -1;
            islem_calistir($sformatf("rnd%0d", i), op, a, b, etk, d, tut, tf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
